byte_stripe_nlane: RTL and testbench
====================================

# byte_stripe_nlane

Parametrised byte-striping stage: accepts one WIDTH-bit word per cycle on `clk_2f` and distributes consecutive valid words round-robin across LANES output lanes. Lanes are published together as one aligned stripe group. The block adds three behaviours to the two-lane striper:
- downstream backpressure,
- explicit flush of partial stripes with a per-lane valid mask,
- a stripe counter.

It sits between the PHY-side data source and the per-lane serialisers.

## Interface
- `WIDTH`, 32, bits per word/lane (≥8).
- `LANES`, 4, lane count; power of two, 2..16.
- `clk_2f`  in  1  single clock; rising edge, input word rate.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  WIDTH  input word.
- `valid_in`  in  1  `data_in` valid; word is accepted when `valid_in && ready_in`.
- `ready_in`  out  1  block can accept a word this cycle.
- `flush_in`  in  1  publish the partial stripe now.
- `lanes_out`  out  LANES*WIDTH  lane k at `[k*WIDTH +: WIDTH]`.
- `valid_out`  out  LANES  per-lane valid mask of the held group.
- `ready_out`  in  1  downstream consumes the held group when `valid_out != 0`.
- `stripe_cnt`  out  16  groups published; wraps from 0xFFFF to 0.

## Operation
- **Staging buffer:** LANES words plus `ptr` (clog2(LANES) bits) plus `fill_mask`.
  - An accepted word goes to staging slot `ptr` and sets `fill_mask[ptr]`.
  - `ptr` increments modulo LANES.
  - When `valid_in`=0, `ptr` holds. Gaps never advance or realign lanes.
- **Output register:** holds one group (`lanes_out`, `valid_out`).
  - It is "held" while `valid_out != 0`.
  - It clears to empty (`valid_out`=0; `lanes_out` retains its data) when `ready_out`=1 in a held cycle.
- **Stripe complete:** a word is accepted at `ptr`=LANES-1. The group can move to the output when the output is empty, or is draining this cycle.
  - If it can move: transfer at that edge with `valid_out` = all ones. Staging clears; `ptr` goes to 0.
  - If not: the FSM enters FULL.
- **FSM states:**
  - FILL: `ready_in`=1.
  - FULL: staging complete, `ready_in`=0. Stays in FULL until the output drains. It then transfers on the same edge as the drain and returns to FILL.
- **Flush:** `flush_in`=1 in FILL with `fill_mask` ≠ 0 (counting a word accepted this same cycle) publishes a partial group.
  - `valid_out` = `fill_mask`. Unfilled lanes are driven with 0.
  - Then `ptr` goes to 0 and `fill_mask` to 0.
  - The partial group is subject to the same output-slot rule. If the output is blocked, the flush is remembered (`flush_pend`) and the FSM enters FULL.
  - `flush_in` with empty staging, or while in FULL, has no additional effect.
- **Word plus flush in one cycle:** the word is included first, then the flush applies.
- **Completion plus flush in one cycle:** equivalent to plain completion.
- **Counter:** `stripe_cnt` increments on each transfer into the output register, full or partial.

## Timing
- **Reset (async assert):**
  - `lanes_out`=0, `valid_out`=0, `stripe_cnt`=0.
  - FSM=FILL, `ptr`=0, `fill_mask`=0.
  - `ready_in`=1 (combinational from the FSM). Inputs are ignored while `reset`=0.
  - Deassertion is sampled synchronously; the first accept is at the first rising edge with `reset`=1.
- **Reset mid-stripe or mid-hold:** all staged and held data is discarded; no partial group is emitted.
- **Latency:** the last word of a stripe, accepted at edge t, appears on `lanes_out`/`valid_out` after edge t (visible in cycle t+1).
- **Throughput:** drain and transfer on the same edge give full rate, one group per LANES cycles with no bubbles, provided `ready_out`=1.
- `ready_in` is a function of FSM state only; there is no combinational path from `ready_out` to `ready_in`.
- The output is held stable (data and mask) until consumed.

## Structure
- **Package `bs_pkg`:**
  - state enum {FILL, FULL}
  - `LANES_DEF`=4, `WIDTH_DEF`=32
  - `CNT_W`=16
  - function computing lane-index width
- **Sub-module `bs_stage_buf`:** LANES×WIDTH staging registers, `ptr`, `fill_mask`, with load/clear ports. The top holds the FSM, output register and counter.

## Test plan
- **Basic stripe:** LANES=2; accept FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC on consecutive cycles with `ready_out`=1 -> groups {lane0=FFFFFFFF, lane1=EEEEEEEE} then {DDDDDDDD, CCCCCCCC}, each with `valid_out`=2'b11; `stripe_cnt`=2.
- **Gap:** LANES=2; accept 3, two idle cycles, accept 4 -> single group {3, 4}, mask 2'b11; no realignment.
- **Backpressure:** LANES=4; `ready_out`=0; stream words 1..8 -> first group held, `ready_in`=0 after word 8 (state FULL). Raise `ready_out` -> group {5,6,7,8} appears on the next edge and `ready_in`=1.
- **Flush:** LANES=4; accept AAAAAAAA, 99999999, then `flush_in` -> `valid_out`=4'b0011, lanes 2-3 = 0. The next word lands in lane 0.
- **Reset mid-stripe:** pulse `reset` low after two accepted words -> all outputs 0, `stripe_cnt`=0. The next four words form a clean group starting at lane 0.
- **Counter wrap:** preload via 65536 groups -> `stripe_cnt` wraps to 0.

Source files
------------

// File: rtl/byte_stripe_nlane_pkg.sv
// Shared types and constants for the byte-striping stage.
package bs_pkg;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  localparam int unsigned LANES_DEF = 4;
  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W     = 16;

  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/byte_stripe_nlane_if.sv
// Word-in / stripe-group-out handshake bundle for byte_stripe_nlane.
interface byte_stripe_nlane_if import bs_pkg::*; #(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LANES = LANES_DEF
);

  logic [WIDTH-1:0]       data_in;
  logic                   valid_in;
  logic                   ready_in;
  logic                   flush_in;
  logic [LANES*WIDTH-1:0] lanes_out;
  logic [LANES-1:0]       valid_out;
  logic                   ready_out;
  logic [CNT_W-1:0]       stripe_cnt;

  modport master (
    output data_in, valid_in, flush_in, ready_out,
    input  ready_in, lanes_out, valid_out, stripe_cnt
  );

  modport slave (
    input  data_in, valid_in, flush_in, ready_out,
    output ready_in, lanes_out, valid_out, stripe_cnt
  );

endinterface

// File: rtl/byte_stripe_nlane_stage_buf.sv
// Staging registers: one slot per lane, write pointer and per-slot fill mask.
module bs_stage_buf import bs_pkg::*; #(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LANES = LANES_DEF,
  localparam int unsigned PTR_W = lane_idx_w(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       word,
  output logic [LANES*WIDTH-1:0] words,
  output logic [PTR_W-1:0]       ptr,
  output logic [LANES-1:0]       fill_mask
);

  logic [WIDTH-1:0] slot [LANES];

  // Clear wins over load: a word arriving on the clearing edge is forwarded by the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < LANES; k++) slot[k] <= '0;
      ptr       <= '0;
      fill_mask <= '0;
    end else if (clear) begin
      for (int unsigned k = 0; k < LANES; k++) slot[k] <= '0;
      ptr       <= '0;
      fill_mask <= '0;
    end else if (load) begin
      slot[ptr]      <= word;
      fill_mask[ptr] <= 1'b1;
      ptr            <= ptr + 1'b1;
    end
  end

  always_comb begin
    words = '0;
    for (int unsigned k = 0; k < LANES; k++) words[k*WIDTH +: WIDTH] = slot[k];
  end

endmodule

// File: rtl/byte_stripe_nlane.sv
// Round-robin word striper with backpressure, partial-stripe flush and group counter.
module byte_stripe_nlane import bs_pkg::*; #(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LANES = LANES_DEF
) (
  input logic               clk_2f,
  input logic               reset,
  byte_stripe_nlane_if.slave bus
);

  localparam int unsigned PTR_W = lane_idx_w(LANES);

  state_t                 state;
  logic                   flush_pend;
  logic [LANES*WIDTH-1:0] lanes_q;
  logic [LANES-1:0]       vmask_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [LANES*WIDTH-1:0] staged, group;
  logic [LANES-1:0]       fill_mask, merged_mask, group_mask;
  logic [PTR_W-1:0]       ptr;
  logic                   accept, complete, flush_req, publish, out_free, xfer;

  bs_stage_buf #(.WIDTH(WIDTH), .LANES(LANES)) u_stage (
    .clk       (clk_2f),
    .rst_n     (reset),
    .load      (accept),
    .clear     (xfer),
    .word      (bus.data_in),
    .words     (staged),
    .ptr       (ptr),
    .fill_mask (fill_mask)
  );

  assign bus.ready_in   = (state == FILL);
  assign bus.lanes_out  = lanes_q;
  assign bus.valid_out  = vmask_q;
  assign bus.stripe_cnt = cnt_q;

  assign accept    = bus.valid_in && (state == FILL);
  assign complete  = accept && (ptr == PTR_W'(LANES - 1));
  assign flush_req = bus.flush_in && (state == FILL) && (merged_mask != '0);
  assign publish   = (state == FULL) || complete || flush_req;
  assign out_free  = (vmask_q == '0) || bus.ready_out;
  assign xfer      = publish && out_free;

  // Same-cycle word is merged into the group so completion and flush see it.
  always_comb begin
    merged_mask = fill_mask;
    if (accept) merged_mask[ptr] = 1'b1;
    group = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (merged_mask[k])
        group[k*WIDTH +: WIDTH] = (accept && ptr == PTR_W'(k)) ? bus.data_in
                                                                : staged[k*WIDTH +: WIDTH];
    end
    group_mask = merged_mask;
    if (state == FULL && !flush_pend) group_mask = '1;
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      flush_pend <= 1'b0;
      lanes_q    <= '0;
      vmask_q    <= '0;
      cnt_q      <= '0;
    end else if (xfer) begin
      lanes_q    <= group;
      vmask_q    <= group_mask;
      cnt_q      <= cnt_q + 1'b1;
      state      <= FILL;
      flush_pend <= 1'b0;
    end else begin
      if (vmask_q != '0 && bus.ready_out) vmask_q <= '0;
      if (state == FILL && (complete || flush_req)) begin
        state      <= FULL;
        flush_pend <= !complete;
      end
    end
  end

endmodule

// File: tb/tb_byte_stripe_nlane.sv
// Directed bench for byte_stripe_nlane with a 2-lane and a 4-lane instance.
module tb_byte_stripe_nlane;
  import bs_pkg::*;

  logic clk_2f = 1'b0;
  logic reset  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_2f = ~clk_2f;

  byte_stripe_nlane_if #(.WIDTH(32), .LANES(2)) b2 ();
  byte_stripe_nlane_if #(.WIDTH(32), .LANES(4)) b4 ();

  byte_stripe_nlane #(.WIDTH(32), .LANES(2)) dut2 (.clk_2f(clk_2f), .reset(reset), .bus(b2));
  byte_stripe_nlane #(.WIDTH(32), .LANES(4)) dut4 (.clk_2f(clk_2f), .reset(reset), .bus(b4));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_2f);
    #1;
  endtask

  initial begin
    b2.data_in = '0; b2.valid_in = 0; b2.flush_in = 0; b2.ready_out = 0;
    b4.data_in = '0; b4.valid_in = 0; b4.flush_in = 0; b4.ready_out = 0;

    // reset state
    step(); step();
    chk("rst_lanes2", b2.lanes_out, 0);
    chk("rst_valid2", b2.valid_out, 0);
    chk("rst_cnt2",   b2.stripe_cnt, 0);
    chk("rst_rdy2",   b2.ready_in, 1);
    chk("rst_lanes4", b4.lanes_out, 0);
    chk("rst_valid4", b4.valid_out, 0);
    chk("rst_rdy4",   b4.ready_in, 1);
    reset = 1'b1;

    // basic stripe, 2 lanes
    b2.ready_out = 1;
    b2.valid_in = 1; b2.data_in = 32'hFFFFFFFF; step();
    b2.data_in = 32'hEEEEEEEE; step();
    chk("basic_g1_lanes", b2.lanes_out, 64'hEEEEEEEE_FFFFFFFF);
    chk("basic_g1_valid", b2.valid_out, 2'b11);
    chk("basic_g1_cnt",   b2.stripe_cnt, 1);
    b2.data_in = 32'hDDDDDDDD; step();
    chk("basic_drained",  b2.valid_out, 0);
    b2.data_in = 32'hCCCCCCCC; step();
    b2.valid_in = 0;
    chk("basic_g2_lanes", b2.lanes_out, 64'hCCCCCCCC_DDDDDDDD);
    chk("basic_g2_valid", b2.valid_out, 2'b11);
    chk("basic_g2_cnt",   b2.stripe_cnt, 2);

    // gap: idle cycles must not realign lanes
    step();
    b2.valid_in = 1; b2.data_in = 32'h3; step();
    b2.valid_in = 0; step(); step();
    chk("gap_idle_valid", b2.valid_out, 0);
    b2.valid_in = 1; b2.data_in = 32'h4; step();
    b2.valid_in = 0;
    chk("gap_lanes", b2.lanes_out, 64'h00000004_00000003);
    chk("gap_valid", b2.valid_out, 2'b11);
    chk("gap_cnt",   b2.stripe_cnt, 3);

    // backpressure, 4 lanes
    b4.ready_out = 0;
    for (int i = 1; i <= 8; i++) begin
      b4.valid_in = 1; b4.data_in = 32'(i); step();
      if (i == 4) begin
        chk("bp_g1_lanes", b4.lanes_out, 128'h00000004_00000003_00000002_00000001);
        chk("bp_g1_valid", b4.valid_out, 4'b1111);
      end
    end
    b4.valid_in = 0;
    chk("bp_full_rdy",   b4.ready_in, 0);
    chk("bp_held_lanes", b4.lanes_out, 128'h00000004_00000003_00000002_00000001);
    chk("bp_held_cnt",   b4.stripe_cnt, 1);
    step();
    chk("bp_still_full", b4.ready_in, 0);
    chk("bp_still_held", b4.valid_out, 4'b1111);
    b4.ready_out = 1; step();
    chk("bp_g2_lanes", b4.lanes_out, 128'h00000008_00000007_00000006_00000005);
    chk("bp_g2_valid", b4.valid_out, 4'b1111);
    chk("bp_g2_rdy",   b4.ready_in, 1);
    chk("bp_g2_cnt",   b4.stripe_cnt, 2);
    step();
    chk("bp_drained", b4.valid_out, 0);

    // flush of a partial stripe
    b4.ready_out = 0;
    b4.valid_in = 1; b4.data_in = 32'hAAAAAAAA; step();
    b4.data_in = 32'h99999999; step();
    b4.valid_in = 0; b4.flush_in = 1; step();
    b4.flush_in = 0;
    chk("fl_valid", b4.valid_out, 4'b0011);
    chk("fl_lanes", b4.lanes_out, 128'h00000000_00000000_99999999_AAAAAAAA);
    chk("fl_cnt",   b4.stripe_cnt, 3);
    b4.ready_out = 1;
    b4.valid_in = 1; b4.data_in = 32'h11; step();
    b4.valid_in = 0; b4.flush_in = 1; step();
    b4.flush_in = 0;
    chk("fl_lane0_valid", b4.valid_out, 4'b0001);
    chk("fl_lane0_lanes", b4.lanes_out, 128'h11);
    chk("fl_lane0_cnt",   b4.stripe_cnt, 4);
    b4.flush_in = 1; step();
    b4.flush_in = 0;
    chk("fl_empty_cnt",   b4.stripe_cnt, 4);
    chk("fl_empty_valid", b4.valid_out, 0);

    // word+flush together, then a flush blocked by a held group
    b4.ready_out = 0;
    b4.valid_in = 1; b4.flush_in = 1; b4.data_in = 32'h21; step();
    chk("wf_valid", b4.valid_out, 4'b0001);
    chk("wf_lanes", b4.lanes_out, 128'h21);
    chk("wf_cnt",   b4.stripe_cnt, 5);
    b4.data_in = 32'h22; step();
    b4.valid_in = 0; b4.flush_in = 0;
    chk("wf_blk_rdy",   b4.ready_in, 0);
    chk("wf_blk_lanes", b4.lanes_out, 128'h21);
    b4.ready_out = 1; step();
    chk("wf_pend_lanes", b4.lanes_out, 128'h22);
    chk("wf_pend_valid", b4.valid_out, 4'b0001);
    chk("wf_pend_cnt",   b4.stripe_cnt, 6);
    chk("wf_pend_rdy",   b4.ready_in, 1);
    step();

    // reset mid-stripe
    b4.valid_in = 1; b4.data_in = 32'h31; step();
    b4.data_in = 32'h32; step();
    b4.valid_in = 0;
    reset = 1'b0;
    #2;
    chk("mrst_lanes", b4.lanes_out, 0);
    chk("mrst_valid", b4.valid_out, 0);
    chk("mrst_cnt",   b4.stripe_cnt, 0);
    chk("mrst_cnt2",  b2.stripe_cnt, 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b4.valid_in = 1; b4.data_in = 32'h41 + 32'(i); step();
      if (i == 2) chk("mrst_no_partial", b4.valid_out, 0);
    end
    b4.valid_in = 0;
    chk("mrst_g_lanes", b4.lanes_out, 128'h00000044_00000043_00000042_00000041);
    chk("mrst_g_valid", b4.valid_out, 4'b1111);
    chk("mrst_g_cnt",   b4.stripe_cnt, 1);

    // counter wrap: one single-word flushed group per cycle
    b2.ready_out = 1; b2.valid_in = 1; b2.flush_in = 1;
    for (int n = 1; n <= 65535; n++) begin
      b2.data_in = 32'(n); step();
    end
    chk("wrap_ffff",  b2.stripe_cnt, 16'hFFFF);
    chk("wrap_valid", b2.valid_out, 2'b01);
    chk("wrap_lanes", b2.lanes_out, 64'h00000000_0000FFFF);
    b2.data_in = 32'h12345678; step();
    b2.valid_in = 0; b2.flush_in = 0;
    chk("wrap_zero",  b2.stripe_cnt, 0);
    chk("wrap_last",  b2.lanes_out, 64'h00000000_12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
